sic_exec_imm_q: RTL
===================

Name: sic_exec_imm_q

Overview:
- Parametrised, queued successor to the single-slot Imm/No-RS sub-SIC.
- Buffers up to DEPTH packets for LUI, J/JAL and other no-operand instructions in a FIFO. The head resolves its ECR dependency, then commits (LUI/LINK writeback) or aborts on mispredict.
- Adds GPR write back-pressure, a flush, occupancy reporting and overflow detection.
- Sits between the issue stage and the register/ECR arbiters in the sub-SIC array.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- ECR_ID_W, 4, ECR index width.
- ID_WIDTH, 6, packet tag width.
- CNT_W, $clog2(DEPTH+1), occupancy width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pkt_valid  in  1  incoming packet strobe
- pkt_pc  in  32  instruction PC
- pkt_imm16  in  16  immediate
- pkt_wb_sel  in  2  0=LUI, 1=LINK, others=zero data
- pkt_write_gpr  in  1  packet writes a GPR
- pkt_dep_ecr_valid  in  1  packet depends on an ECR
- pkt_dep_ecr_id  in  ECR_ID_W  ECR index
- pkt_tag  in  ID_WIDTH  packet tag
- flush  in  1  drop all entries
- req_instr  out  1  request next packet
- ecr_read_en  out  1  ECR read strobe
- ecr_read_addr  out  ECR_ID_W  ECR read index
- ecr_read_data  in  2  00 pending, 01 correct, 10 mispredict, 11 pending
- reg_wdata  out  32  writeback data
- reg_wtag  out  ID_WIDTH  tag of the committing packet
- reg_wcommit  out  1  write strobe
- reg_wready  in  1  register port accepts the write this cycle
- retire  out  1  head left the queue this cycle (commit or abort)
- occupancy  out  CNT_W  valid entries
- overflow_err  out  1  sticky protocol violation

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, read and write pointers =0, overflow_err=0.
  - While rst is asserted, all outputs are 0 except req_instr, which is also 0.
- Storage: circular FIFO; pointers wrap modulo DEPTH.
- Push: the packet is written on the clk edge where pkt_valid=1 and count<DEPTH (count measured before any pop that cycle).
- Push into a full FIFO (count==DEPTH, even if a pop happens that cycle):
  - packet dropped;
  - overflow_err set, and held until rst.
- Head evaluation is combinational on the head entry and gated by count>0:
  - ecr_read_en = head_valid && head.dep_ecr_valid.
  - ecr_read_addr = head.dep_ecr_id when the head is valid, else 0.
  - ecr_ok = !head.dep_ecr_valid || ecr_read_data==01.
  - abort = ecr_read_en && ecr_read_data==10.
  - commit = head_valid && ecr_ok && !abort && (!head.write_gpr || reg_wready).
- Write data:
  - reg_wdata = {imm16,16'h0} for LUI;
  - reg_wdata = pc+4 (32-bit wrap) for LINK;
  - reg_wdata = 0 otherwise;
  - reg_wdata is 0 whenever there is no valid head.
  - reg_wtag = head tag.
- Write strobe: reg_wcommit = commit && head.write_gpr.
- Retire and pop:
  - retire = commit || abort; the head pops on that edge.
  - A head with write_gpr=0 retires without waiting on reg_wready.
  - A head with write_gpr=1 stalls while reg_wready=0; data and tag stay stable.
- ECR ordering: a head whose ECR reads 00/11 stalls the whole queue; retirement is strictly in order.
- Issue request: req_instr = !rst && !flush && (count + pkt_valid) < DEPTH.
  - Issue delivers at most one packet, one cycle after a granted request.
  - This rule guarantees no overflow under a legal issuer.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push into an empty FIFO: the packet becomes head next cycle (minimum one-cycle latency from pkt_valid to commit).
- Flush:
  - on the edge: count=0, pointers=0, and a packet arriving in the same cycle is dropped;
  - in the cycle: reg_wcommit, retire and ecr_read_en are forced to 0.
- Occupancy: occupancy = count (registered).

Test Plan:
- LUI: push LUI imm16=16'h1234, write_gpr=1, no dependency, reg_wready=1 -> reg_wcommit=1 with reg_wdata=32'h12340000 on the next cycle; retire=1; occupancy goes 1 -> 0.
- JAL with dependency: push JAL pc=32'h0040_0010, dep ECR 3. Hold ecr_read_data=00 for 3 cycles -> ecr_read_en=1, ecr_read_addr=3, no commit. Drive 01 -> reg_wdata=32'h0040_0014 and reg_wcommit=1.
- Mispredict abort: queue 3 packets, head dep ECR=10 -> retire=1 with reg_wcommit=0. The remaining two commit in order in subsequent cycles with their tags.
- Back-pressure: head LUI with reg_wready=0 for 5 cycles -> reg_wdata/reg_wtag stable, no pop. A following J (write_gpr=0) does not bypass it.
- Full and overflow: fill DEPTH=4 with the head stalled -> req_instr=0 once count+pkt_valid==4. Force a 5th pkt_valid -> packet dropped, overflow_err=1 until rst.
- Flush and reset: flush with 3 entries plus an incoming packet -> occupancy=0 next cycle and no commit. Assert rst mid-stall -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/sic_exec_imm_q_if.sv
// Issue/ECR/register-port bundle for the queued Imm/No-RS sub-SIC.
// The master side is the surrounding array (issue, ECR file, register arbiter); the slave side is the queue.
interface sic_exec_imm_q_if #(
    parameter int ECR_ID_W = 4,
    parameter int ID_WIDTH = 6,
    parameter int CNT_W    = 3
);
    logic                pkt_valid;
    logic [31:0]         pkt_pc;
    logic [15:0]         pkt_imm16;
    logic [1:0]          pkt_wb_sel;
    logic                pkt_write_gpr;
    logic                pkt_dep_ecr_valid;
    logic [ECR_ID_W-1:0] pkt_dep_ecr_id;
    logic [ID_WIDTH-1:0] pkt_tag;
    logic                flush;
    logic                req_instr;
    logic                ecr_read_en;
    logic [ECR_ID_W-1:0] ecr_read_addr;
    logic [1:0]          ecr_read_data;
    logic [31:0]         reg_wdata;
    logic [ID_WIDTH-1:0] reg_wtag;
    logic                reg_wcommit;
    logic                reg_wready;
    logic                retire;
    logic [CNT_W-1:0]    occupancy;
    logic                overflow_err;

    // A packet is taken on any edge with pkt_valid=1 and room; req_instr only advertises room for the
    // next cycle. A register write completes on the edge where reg_wcommit=1, which is only raised
    // while reg_wready=1.
    modport master (
        output pkt_valid, pkt_pc, pkt_imm16, pkt_wb_sel, pkt_write_gpr,
               pkt_dep_ecr_valid, pkt_dep_ecr_id, pkt_tag, flush,
               ecr_read_data, reg_wready,
        input  req_instr, ecr_read_en, ecr_read_addr, reg_wdata, reg_wtag,
               reg_wcommit, retire, occupancy, overflow_err
    );

    modport slave (
        input  pkt_valid, pkt_pc, pkt_imm16, pkt_wb_sel, pkt_write_gpr,
               pkt_dep_ecr_valid, pkt_dep_ecr_id, pkt_tag, flush,
               ecr_read_data, reg_wready,
        output req_instr, ecr_read_en, ecr_read_addr, reg_wdata, reg_wtag,
               reg_wcommit, retire, occupancy, overflow_err
    );
endinterface

// File: rtl/sic_exec_imm_q.sv
// Queued Imm/No-RS sub-SIC: FIFO of LUI / J / JAL packets whose head waits on its ECR,
// then commits its writeback (respecting register back-pressure) or aborts on mispredict.
module sic_exec_imm_q #(
    parameter int DEPTH    = 4,
    parameter int ECR_ID_W = 4,
    parameter int ID_WIDTH = 6,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input logic                clk,
    input logic                rst,
    sic_exec_imm_q_if.slave    bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]         pc;
        logic [15:0]         imm16;
        logic [1:0]          wb_sel;
        logic                write_gpr;
        logic                dep_ecr_valid;
        logic [ECR_ID_W-1:0] dep_ecr_id;
        logic [ID_WIDTH-1:0] tag;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    entry_t             w_head;
    entry_t             w_pkt;
    logic               w_full;
    logic               w_head_valid;
    logic               w_dep_rd;
    logic               w_ecr_ok;
    logic               w_abort;
    logic               w_commit;
    logic               w_pop;
    logic               w_push;
    logic [CNT_W:0]     w_demand;
    logic [31:0]        w_wdata;

    always_comb begin
        w_pkt.pc            = bus.pkt_pc;
        w_pkt.imm16         = bus.pkt_imm16;
        w_pkt.wb_sel        = bus.pkt_wb_sel;
        w_pkt.write_gpr     = bus.pkt_write_gpr;
        w_pkt.dep_ecr_valid = bus.pkt_dep_ecr_valid;
        w_pkt.dep_ecr_id    = bus.pkt_dep_ecr_id;
        w_pkt.tag           = bus.pkt_tag;
    end

    // Head logic; flush suppresses every side effect of the head in its own cycle.
    always_comb begin
        w_head       = r_mem[r_rd_ptr];
        w_full       = (r_count == FULL_CNT);
        w_head_valid = !rst && (r_count != '0);
        w_dep_rd     = w_head_valid && w_head.dep_ecr_valid;
        w_ecr_ok     = !w_head.dep_ecr_valid || (bus.ecr_read_data == 2'b01);
        w_abort      = w_dep_rd && (bus.ecr_read_data == 2'b10) && !bus.flush;
        w_commit     = w_head_valid && w_ecr_ok && !w_abort && !bus.flush &&
                       (!w_head.write_gpr || bus.reg_wready);
        w_pop        = w_commit || w_abort;
        w_push       = !rst && !bus.flush && bus.pkt_valid && !w_full;
        w_demand     = {1'b0, r_count} + {{CNT_W{1'b0}}, bus.pkt_valid};
        w_wdata      = '0;
        if (w_head_valid) begin
            case (w_head.wb_sel)
                2'd0:    w_wdata = {w_head.imm16, 16'h0000};
                2'd1:    w_wdata = w_head.pc + 32'd4;
                default: w_wdata = '0;
            endcase
        end
    end

    assign bus.req_instr     = !rst && !bus.flush && (w_demand < {1'b0, FULL_CNT});
    assign bus.ecr_read_en   = w_dep_rd && !bus.flush;
    assign bus.ecr_read_addr = w_head_valid ? w_head.dep_ecr_id : '0;
    assign bus.reg_wdata     = w_wdata;
    assign bus.reg_wtag      = w_head_valid ? w_head.tag : '0;
    assign bus.reg_wcommit   = w_commit && w_head.write_gpr;
    assign bus.retire        = w_pop;
    assign bus.occupancy     = rst ? '0 : r_count;
    assign bus.overflow_err  = !rst && r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Fullness is judged before any same-cycle pop, so a push into a full queue is lost.
            if (bus.pkt_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule
